// File: rtl/ga_pipeline_ctrl.sv
// Generation sequencer for the GA pipeline: select -> crossover -> mutate -> evaluate -> population write.
// Issues one-cycle stage starts, waits on each stage done under a watchdog, and tracks iterations and the first perfect child.
module ga_pipeline_ctrl #(
  parameter int                       FITNESS_WIDTH  = 14,
  parameter logic [FITNESS_WIDTH-1:0] MAX_FITNESS    = 14'h3FFF,
  parameter int                       TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [31:0]              target_iteration,
  output logic                     start_select,
  input  logic                     select_done,
  output logic                     start_cross,
  input  logic                     cross_done,
  output logic                     start_mutate,
  input  logic                     mutate_done,
  output logic                     start_eval,
  input  logic                     eval_done,
  input  logic [FITNESS_WIDTH-1:0] child_fitness,
  output logic                     start_pop_write,
  input  logic                     pop_write_done,
  output logic                     busy,
  output logic                     done,
  output logic                     perfect_found,
  output logic                     stage_timeout,
  output logic [31:0]              iteration_count,
  output logic [31:0]              crossovers_to_perfect,
  output logic [2:0]               pipeline_state
);

  typedef enum logic [2:0] {
    P_IDLE      = 3'd0,
    P_SELECT    = 3'd1,
    P_CROSSOVER = 3'd2,
    P_MUTATION  = 3'd3,
    P_EVALUATE  = 3'd4,
    P_UPDATE    = 3'd5,
    P_DONE      = 3'd6
  } state_e;

  // Watchdog value seen in the last waiting cycle; the stage has then spent TIMEOUT_CYCLES cycles.
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_r, state_s;
  logic        first_r;
  logic [7:0]  wd_r;
  logic [31:0] target_r;
  logic [31:0] cross_cnt_r;
  logic        is_stage_s, stage_done_s, honour_s, expire_s;
  logic        accept_s, cross_hon_s, perfect_hit_s, pop_hon_s, timeout_s;
  logic [32:0] iter_inc_s;

  assign pipeline_state = state_r;

  // Next-state selection and the per-cycle events that update counters and flags
  always_comb begin
    state_s       = state_r;
    stage_done_s  = 1'b0;
    accept_s      = 1'b0;
    cross_hon_s   = 1'b0;
    perfect_hit_s = 1'b0;
    pop_hon_s     = 1'b0;
    timeout_s     = 1'b0;
    is_stage_s    = state_r inside {P_SELECT, P_CROSSOVER, P_MUTATION, P_EVALUATE, P_UPDATE};
    iter_inc_s    = {1'b0, iteration_count} + 33'd1;
    case (state_r)
      P_SELECT:    stage_done_s = select_done;
      P_CROSSOVER: stage_done_s = cross_done;
      P_MUTATION:  stage_done_s = mutate_done;
      P_EVALUATE:  stage_done_s = eval_done;
      P_UPDATE:    stage_done_s = pop_write_done;
      default:     stage_done_s = 1'b0;
    endcase
    // The entry cycle carries the start pulse, so a done there is never honoured.
    honour_s = is_stage_s && !first_r && stage_done_s;
    expire_s = is_stage_s && (wd_r == WD_LAST);
    case (state_r)
      P_IDLE, P_DONE: begin
        if (start) begin
          accept_s = 1'b1;
          state_s  = (target_iteration == 32'd0) ? P_DONE : P_SELECT;
        end else begin
          state_s = state_r;
        end
      end
      P_SELECT, P_CROSSOVER, P_MUTATION, P_EVALUATE, P_UPDATE: begin
        if (abort) begin
          state_s = P_DONE;
        end else if (honour_s) begin
          case (state_r)
            P_SELECT:    state_s = P_CROSSOVER;
            P_CROSSOVER: begin
              state_s     = P_MUTATION;
              cross_hon_s = 1'b1;
            end
            P_MUTATION:  state_s = P_EVALUATE;
            P_EVALUATE:  begin
              state_s       = P_UPDATE;
              perfect_hit_s = (child_fitness == MAX_FITNESS) && !perfect_found;
            end
            P_UPDATE:    begin
              pop_hon_s = 1'b1;
              state_s   = (perfect_found || (iter_inc_s >= {1'b0, target_r})) ? P_DONE : P_SELECT;
            end
            default:     state_s = P_IDLE;
          endcase
        end else if (expire_s) begin
          timeout_s = 1'b1;
          state_s   = P_DONE;
        end else begin
          state_s = state_r;
        end
      end
      default: state_s = P_IDLE;
    endcase
  end

  // State, watchdog, registered stage pulses, status outputs and run counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r               <= P_IDLE;
      first_r               <= 1'b0;
      wd_r                  <= 8'd0;
      target_r              <= 32'd0;
      cross_cnt_r           <= 32'd0;
      start_select          <= 1'b0;
      start_cross           <= 1'b0;
      start_mutate          <= 1'b0;
      start_eval            <= 1'b0;
      start_pop_write       <= 1'b0;
      busy                  <= 1'b0;
      done                  <= 1'b0;
      perfect_found         <= 1'b0;
      stage_timeout         <= 1'b0;
      iteration_count       <= 32'd0;
      crossovers_to_perfect <= 32'd0;
    end else begin
      state_r         <= state_s;
      first_r         <= (state_s != state_r);
      wd_r            <= (state_s != state_r) ? 8'd0 : (is_stage_s ? wd_r + 8'd1 : wd_r);
      start_select    <= (state_s == P_SELECT)    && (state_r != P_SELECT);
      start_cross     <= (state_s == P_CROSSOVER) && (state_r != P_CROSSOVER);
      start_mutate    <= (state_s == P_MUTATION)  && (state_r != P_MUTATION);
      start_eval      <= (state_s == P_EVALUATE)  && (state_r != P_EVALUATE);
      start_pop_write <= (state_s == P_UPDATE)    && (state_r != P_UPDATE);
      busy            <= state_s inside {P_SELECT, P_CROSSOVER, P_MUTATION, P_EVALUATE, P_UPDATE};
      done            <= (state_s == P_DONE);
      if (accept_s) begin
        target_r              <= target_iteration;
        cross_cnt_r           <= 32'd0;
        iteration_count       <= 32'd0;
        crossovers_to_perfect <= 32'd0;
        perfect_found         <= 1'b0;
        stage_timeout         <= 1'b0;
      end else begin
        if (cross_hon_s) cross_cnt_r <= cross_cnt_r + 32'd1;
        if (perfect_hit_s) begin
          perfect_found         <= 1'b1;
          crossovers_to_perfect <= cross_cnt_r;
        end
        if (pop_hon_s && (iteration_count != 32'hFFFF_FFFF)) iteration_count <= iteration_count + 32'd1;
        if (timeout_s) stage_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: doc/ga_pipeline_ctrl.md
Name: ga_pipeline_ctrl

Overview:
Sequencer for the GA generation pipeline inside ga_top: select -> crossover -> mutate -> evaluate -> population write. It drives one-cycle start pulses to each stage unit and waits for that unit's done. It also counts iterations and crossovers, detects a perfect child, and terminates on target iteration, perfect fitness, abort or stage timeout. It replaces ad-hoc pipeline sequencing in ga_top. ga_top's S_RUNNING state hands control to this block via start.

Parameters:
FITNESS_WIDTH, 14, width of child fitness.
MAX_FITNESS, 14'h3FFF, fitness value that counts as perfect.
TIMEOUT_CYCLES, 255, maximum cycles a stage may wait for its done (8-bit watchdog).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous reset, active-low.
start  in  1  one-cycle request to begin a run; accepted only in P_IDLE or P_DONE.
abort  in  1  level; forces termination.
target_iteration  in  32  generations to run; sampled when start is accepted.
start_select / select_done  out / in  1 / 1  selection stage handshake.
start_cross / cross_done  out / in  1 / 1  crossover stage handshake.
start_mutate / mutate_done  out / in  1 / 1  mutation stage handshake.
start_eval / eval_done  out / in  1 / 1  fitness evaluator handshake.
child_fitness  in  FITNESS_WIDTH  evaluator result; valid while eval_done=1.
start_pop_write / pop_write_done  out / in  1 / 1  population update handshake.
busy  out  1  high in P_SELECT..P_UPDATE.
done  out  1  high (level) in P_DONE.
perfect_found  out  1  sticky; set on perfect child.
stage_timeout  out  1  sticky; set on watchdog expiry.
iteration_count  out  32  completed generations.
crossovers_to_perfect  out  32  crossover count at the first perfect child.
pipeline_state  out  3  current state encoding, for debug and logging.

Behaviour:
- State encoding: P_IDLE=0, P_SELECT=1, P_CROSSOVER=2, P_MUTATION=3, P_EVALUATE=4, P_UPDATE=5, P_DONE=6. Value 7 is unreachable; it recovers to P_IDLE.
- Reset (rst=0, asynchronous): state P_IDLE; all outputs 0; internal target register, crossover counter and watchdog cleared.
- Start accepted in P_IDLE or P_DONE:
  - Clears iteration_count, crossover counter, crossovers_to_perfect, perfect_found and stage_timeout.
  - Latches target_iteration.
  - If target_iteration==0, next state is P_DONE; otherwise next state is P_SELECT.
- start while busy=1 is ignored.
- Stage protocol:
  - The start_* pulse is registered and lasts exactly one cycle: the first cycle in the stage state.
  - The stage's done is honoured only from the cycle after its start pulse. A done in the same cycle as the start is ignored.
  - On an honoured done, the next state is the next stage. Minimum two cycles per stage, so one generation takes 10 cycles at minimum.
- done inputs not belonging to the current state are ignored.
- Crossover counter increments on each honoured cross_done.
- Perfect detection, on honoured eval_done with child_fitness==MAX_FITNESS while perfect_found=0:
  - perfect_found<=1.
  - crossovers_to_perfect<=current crossover count.
  - The pipeline still proceeds to P_UPDATE so the perfect child is written.
- On honoured pop_write_done: iteration_count<=iteration_count+1. The next state is then:
  - P_DONE if perfect_found=1, or if iteration_count+1 >= latched target;
  - otherwise P_SELECT.
- Watchdog:
  - Cleared on every state entry; increments each cycle while waiting in a stage state.
  - On reaching TIMEOUT_CYCLES without the stage's done: stage_timeout<=1 and next state is P_DONE.
  - A done arriving in the same cycle as expiry wins: normal transition, no timeout.
- abort=1 in any busy state: next state is P_DONE; no further start_* pulses; counters frozen. abort in P_IDLE or P_DONE has no effect.
- P_DONE: done=1, busy=0. It holds until a new start or reset.
- iteration_count saturates at 2^32-1; it never wraps.

Test Plan:
- Nominal run: target_iteration=3; every stage returns done 2 cycles after its start; child_fitness=100 -> exactly 3 start_select pulses; iteration_count=3; done=1 at cycle 31 after start (30 stage cycles plus one entry cycle); perfect_found=0.
- Perfect child: target_iteration=20; child_fitness=14'h3FFF on the 2nd evaluation -> perfect_found=1; crossovers_to_perfect=2; one more start_pop_write issued; iteration_count=2; done=1.
- Timeout: mutate_done never asserted, TIMEOUT_CYCLES=255 -> stage_timeout=1 and P_DONE exactly 255 cycles after the start_mutate pulse. Repeat with mutate_done at cycle 255 -> no timeout, normal progress.
- Abort mid-run: abort pulsed during P_CROSSOVER of iteration 1 -> P_DONE next cycle; no start_mutate issued; iteration_count=1.
- Handshake robustness: cross_done held high during P_SELECT, and eval_done asserted in the same cycle as start_eval -> both ignored; sequencing order unchanged.
- Reset and restart: rst=0 asserted mid-P_EVALUATE -> all outputs 0 immediately. start with target_iteration=0 -> done=1 after one cycle with no start_* pulses. A second start from P_DONE clears perfect_found and stage_timeout.
